// File: rtl/instruction_fetch_pkg.sv
// Purpose: shared ISA encodings, FSM state type and helpers for the fetch/decode front end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package instruction_fetch_pkg;

   // Fetch/issue sequencer states
   typedef enum logic [1:0] {
      ST_FETCH       = 2'd0,
      ST_ISSUE       = 2'd1,
      ST_BRANCH_WAIT = 2'd2
   } fetch_state_t;

   // Opcodes, bits [31:29]; an all-zero word is a NOP, codes 5..7 are undefined
   localparam logic [2:0] OPC_NOP = 3'd0;
   localparam logic [2:0] OPC_MOV = 3'd1;
   localparam logic [2:0] OPC_ACC = 3'd2;
   localparam logic [2:0] OPC_JMP = 3'd3;
   localparam logic [2:0] OPC_ATC = 3'd4;

   // JMP condition codes carried in the op field
   localparam logic [2:0] COND_UNC = 3'd0;
   localparam logic [2:0] COND_EQ  = 3'd1;
   localparam logic [2:0] COND_NE  = 3'd2;
   localparam logic [2:0] COND_SLT = 3'd3;
   localparam logic [2:0] COND_SGT = 3'd4;

   // MOV sub-operations
   localparam logic [2:0] MOV_PUR = 3'd0;

   // Argument type bits
   localparam logic ARG_NUM = 1'b0;
   localparam logic ARG_REG = 1'b1;

   // Register selectors used as REG arguments
   localparam logic [7:0] REG_DOUT = 8'd1;

   // Flag register bit indices (ATC tests flags[op])
   localparam logic [2:0] FLAG_ZERO  = 3'd0;
   localparam logic [2:0] FLAG_CARRY = 3'd1;
   localparam logic [2:0] FLAG_OFLW  = 3'd2;
   localparam logic [2:0] FLAG_NEG   = 3'd3;

   // True when the instruction must be handed to the execute stage
   function automatic logic needs_exec(input logic [2:0] opcode, input logic [2:0] op);
      return (opcode == OPC_MOV) || (opcode == OPC_ACC) ||
             ((opcode == OPC_JMP) && (op != COND_UNC));
   endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purpose: slice the latched instruction word into its fields.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow the IR directly.
module instruction_decoder
   import instruction_fetch_pkg::*;
(
   input  logic [31:0] i_ir,
   output logic [2:0]  o_opcode,
   output logic [2:0]  o_op,
   output logic        o_arg1_type,
   output logic [7:0]  o_arg1,
   output logic        o_arg2_type,
   output logic [7:0]  o_arg2,
   output logic [7:0]  o_target
);

   // Fixed field map of the 32-bit instruction word
   always_comb begin
      o_opcode    = i_ir[31:29];
      o_op        = i_ir[28:26];
      o_arg1_type = i_ir[25];
      o_arg1      = i_ir[24:17];
      o_arg2_type = i_ir[16];
      o_arg2      = i_ir[15:8];
      o_target    = i_ir[7:0];
   end

endmodule

// File: rtl/instruction_fetch.sv
// Purpose: fetch one instruction word, decode it and issue it or resolve control flow locally.
// Latency: 2 cycles per instruction (FETCH, ISSUE); conditional JMP adds >= 1 BRANCH_WAIT cycle.
// Backpressure: exec_valid holds with stable fields until exec_ready; branch resolution waits on branch_valid.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'd0
) (
   input  logic        clock,
   input  logic        reset,
   output logic [7:0]  address,
   input  logic [31:0] instruction,
   input  logic [7:0]  flags,
   output logic [7:0]  flag_clear,
   output logic        exec_valid,
   input  logic        exec_ready,
   output logic [2:0]  opcode,
   output logic [2:0]  op,
   output logic        arg1_type,
   output logic [7:0]  arg1,
   output logic        arg2_type,
   output logic [7:0]  arg2,
   output logic [7:0]  target,
   input  logic        branch_valid,
   input  logic        branch_taken
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic [7:0]   r_pc;
   logic [7:0]   w_next_pc;
   logic [7:0]   w_pc_inc;
   logic [31:0]  r_ir;
   logic [31:0]  w_next_ir;
   logic         w_exec_valid;
   logic [7:0]   w_flag_clear;

   // All decoded fields come from the IR, never from the live memory bus
   instruction_decoder u_decoder (
      .i_ir        (r_ir),
      .o_opcode    (opcode),
      .o_op        (op),
      .o_arg1_type (arg1_type),
      .o_arg1      (arg1),
      .o_arg2_type (arg2_type),
      .o_arg2      (arg2),
      .o_target    (target)
   );

   assign address    = r_pc;
   assign exec_valid = w_exec_valid;
   assign flag_clear = w_flag_clear;

   // State, PC and IR registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_ir    <= '0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         r_ir    <= w_next_ir;
      end
   end

   // Next-state, next-PC and handshake/strobe outputs
   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_ir    = r_ir;
      w_exec_valid = 1'b0;
      w_flag_clear = 8'd0;
      w_pc_inc     = r_pc + 8'd1;   // wraps 255 -> 0

      case (r_state)
         ST_FETCH: begin
            w_next_ir    = instruction;
            w_next_state = ST_ISSUE;
         end

         ST_ISSUE: begin
            if (needs_exec(opcode, op)) begin
               // MOV, ACC, conditional JMP: hold until the execute stage takes it
               w_exec_valid = 1'b1;
               if (exec_ready) begin
                  if (opcode == OPC_JMP) begin
                     w_next_state = ST_BRANCH_WAIT;
                  end else begin
                     w_next_pc    = w_pc_inc;
                     w_next_state = ST_FETCH;
                  end
               end
            end else if (opcode == OPC_JMP) begin
               // unconditional jump resolves here without the execute stage
               w_next_pc    = target;
               w_next_state = ST_FETCH;
            end else if (opcode == OPC_ATC) begin
               // test-and-clear flag[op]: jump and clear it when set
               if (flags[op]) begin
                  w_next_pc    = target;
                  w_flag_clear = 8'd1 << op;
               end else begin
                  w_next_pc = w_pc_inc;
               end
               w_next_state = ST_FETCH;
            end else begin
               // NOP and undefined opcodes just step the PC
               w_next_pc    = w_pc_inc;
               w_next_state = ST_FETCH;
            end
         end

         ST_BRANCH_WAIT: begin
            if (branch_valid) begin
               w_next_pc    = branch_taken ? target : w_pc_inc;
               w_next_state = ST_FETCH;
            end
         end

         default: begin
            w_next_state = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: self-checking bench for instruction_fetch: directed program plus randomized programs.
// Latency: model tracks the architectural PC and expected per-cycle handshake activity.
// Backpressure: exec_ready stalls and branch_valid delays are randomized or forced per instruction.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   localparam logic [7:0] TB_RESET_PC = 8'd0;

   logic        clock;
   logic        reset;
   logic [7:0]  address;
   logic [31:0] instruction;
   logic [7:0]  flags;
   logic [7:0]  flag_clear;
   logic        exec_valid;
   logic        exec_ready;
   logic [2:0]  opcode;
   logic [2:0]  op;
   logic        arg1_type;
   logic [7:0]  arg1;
   logic        arg2_type;
   logic [7:0]  arg2;
   logic [7:0]  target;
   logic        branch_valid;
   logic        branch_taken;

   logic [31:0] mem [256];
   logic [7:0]  m_pc;
   int          n_checks;
   int          n_errors;

   // per-instruction overrides; -1 selects a random choice
   int g_stall  = -1;
   int g_bdelay = -1;
   int g_taken  = -1;
   int g_flags  = -1;

   instruction_fetch #(.RESET_PC(TB_RESET_PC)) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .instruction  (instruction),
      .flags        (flags),
      .flag_clear   (flag_clear),
      .exec_valid   (exec_valid),
      .exec_ready   (exec_ready),
      .opcode       (opcode),
      .op           (op),
      .arg1_type    (arg1_type),
      .arg1         (arg1),
      .arg2_type    (arg2_type),
      .arg2         (arg2),
      .target       (target),
      .branch_valid (branch_valid),
      .branch_taken (branch_taken)
   );

   assign instruction = mem[address];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (pc %0d, t=%0t)", tag, got, exp, m_pc, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] opc, input logic [2:0] opx,
                                      input logic a1t, input logic [7:0] a1,
                                      input logic a2t, input logic [7:0] a2,
                                      input logic [7:0] tgt);
      return {opc, opx, a1t, a1, a2t, a2, tgt};
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic clear_overrides();
      g_stall  = -1;
      g_bdelay = -1;
      g_taken  = -1;
      g_flags  = -1;
   endtask

   // Runs one instruction. Entered at the negedge of its FETCH cycle,
   // leaves at the negedge of the following instruction's FETCH cycle.
   task automatic step_instr();
      logic [31:0] w;
      logic [2:0]  opc;
      logic [2:0]  opx;
      logic [7:0]  tgt;
      logic [7:0]  fl;
      logic [7:0]  exp_fc;
      logic        tk;
      logic        is_cond;
      int          n;
      int          d;
      w       = mem[m_pc];
      opc     = w[31:29];
      opx     = w[28:26];
      tgt     = w[7:0];
      is_cond = (opc == OPC_JMP) && (opx != COND_UNC);

      chk("fetch_addr", {24'd0, address}, {24'd0, m_pc});
      chk("fetch_ev", {31'd0, exec_valid}, 32'd0);
      chk("fetch_fc", {24'd0, flag_clear}, 32'd0);
      fl           = (g_flags >= 0) ? 8'(g_flags) : 8'($urandom);
      flags        = fl;
      exec_ready   = rbit();
      branch_valid = rbit();
      branch_taken = rbit();
      @(negedge clock);

      if (opc == OPC_MOV || opc == OPC_ACC || is_cond) begin
         n = (g_stall >= 0) ? g_stall : int'($urandom_range(0, 3));
         for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clock);
            chk("iss_ev", {31'd0, exec_valid}, 32'd1);
            chk("iss_addr", {24'd0, address}, {24'd0, m_pc});
            chk("iss_fc", {24'd0, flag_clear}, 32'd0);
            chk("iss_fields", {opcode, op, arg1_type, arg1, arg2_type, arg2, target}, w);
            exec_ready   = (k == n);
            branch_valid = rbit();
            branch_taken = rbit();
         end
         if (!is_cond) begin
            m_pc = m_pc + 8'd1;
         end else begin
            d  = (g_bdelay >= 0) ? g_bdelay : int'($urandom_range(0, 3));
            tk = (g_taken >= 0) ? g_taken[0] : rbit();
            for (int j = 0; j <= d; j++) begin
               @(negedge clock);
               chk("bw_ev", {31'd0, exec_valid}, 32'd0);
               chk("bw_addr", {24'd0, address}, {24'd0, m_pc});
               chk("bw_fc", {24'd0, flag_clear}, 32'd0);
               exec_ready   = rbit();
               branch_valid = (j == d);
               branch_taken = (j == d) ? tk : rbit();
            end
            m_pc = tk ? tgt : m_pc + 8'd1;
         end
      end else begin
         exp_fc = (opc == OPC_ATC && fl[opx]) ? (8'd1 << opx) : 8'd0;
         chk("iss_ev", {31'd0, exec_valid}, 32'd0);
         chk("iss_addr", {24'd0, address}, {24'd0, m_pc});
         chk("iss_fc", {24'd0, flag_clear}, {24'd0, exp_fc});
         chk("iss_fields", {opcode, op, arg1_type, arg1, arg2_type, arg2, target}, w);
         exec_ready = rbit();
         if (opc == OPC_JMP)                    m_pc = tgt;
         else if (opc == OPC_ATC && fl[opx])    m_pc = tgt;
         else                                   m_pc = m_pc + 8'd1;
      end

      @(negedge clock);
      exec_ready   = 1'b0;
      branch_valid = 1'b0;
      branch_taken = 1'b0;
      clear_overrides();
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b0;
      flags        = 8'd0;
      exec_ready   = 1'b0;
      branch_valid = 1'b0;
      branch_taken = 1'b0;
      m_pc         = TB_RESET_PC;

      // directed program
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[0]  = mk(OPC_MOV, MOV_PUR, ARG_NUM, 8'd1, ARG_REG, REG_DOUT, 8'd0);
      mem[1]  = mk(OPC_JMP, COND_UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd12);
      mem[12] = mk(OPC_JMP, COND_UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd20);
      mem[20] = mk(OPC_ATC, FLAG_OFLW, 1'b0, 8'd0, 1'b0, 8'd0, 8'd16);
      mem[16] = mk(OPC_JMP, COND_SLT, 1'b0, 8'd0, 1'b0, 8'd0, 8'd4);
      mem[4]  = mk(OPC_ATC, FLAG_OFLW, 1'b0, 8'd0, 1'b0, 8'd0, 8'd16);
      mem[5]  = mk(OPC_JMP, COND_UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd16);
      mem[17] = mk(OPC_JMP, COND_UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd254);

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_addr", {24'd0, address}, {24'd0, TB_RESET_PC});
      chk("rst_ev", {31'd0, exec_valid}, 32'd0);
      chk("rst_fc", {24'd0, flag_clear}, 32'd0);
      chk("rst_opcode", {29'd0, opcode}, 32'd0);
      reset = 1'b1;

      g_stall = 0;                   step_instr();   // MOV at 0
      step_instr();                                  // JMP UNC 12
      step_instr();                                  // JMP UNC 20
      g_flags = 32'(8'd1 << FLAG_OFLW); step_instr();   // ATC taken -> 16
      g_bdelay = 3; g_taken = 1;     step_instr();   // SLT taken -> 4
      g_flags = 32'(~(8'd1 << FLAG_OFLW)); step_instr();// ATC not taken -> 5
      step_instr();                                  // JMP UNC 16
      g_bdelay = 3; g_taken = 0;     step_instr();   // SLT not taken -> 17
      step_instr();                                  // JMP UNC 254
      step_instr();                                  // NOP 254
      step_instr();                                  // NOP 255 wraps to 0
      chk("wrap_pc", {24'd0, address}, 32'd0);

      // reset asserted while MOV is waiting in ISSUE
      exec_ready = 1'b0;
      @(negedge clock);
      chk("mid_pre_ev", {31'd0, exec_valid}, 32'd1);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_addr", {24'd0, address}, {24'd0, TB_RESET_PC});
      chk("mid_rst_ev", {31'd0, exec_valid}, 32'd0);
      chk("mid_rst_fc", {24'd0, flag_clear}, 32'd0);
      reset = 1'b1;
      m_pc  = TB_RESET_PC;

      g_stall = 5;                   step_instr();   // MOV stalled 5 cycles
      step_instr();

      // randomized programs
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = $urandom;
         for (int s = 0; s < 120; s++) step_instr();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
